// File: rtl/data_mem_pkg.sv
// data_mem_pkg: size codes, FSM states and misalignment check shared by the data memory
package data_mem_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  function automatic logic isMisaligned(input logic [1:0] size, input logic [2:0] low, input logic is64);
    return size == SZ_B ? 1'b0 : size == SZ_H ? low[0] : size == SZ_W ? |low[1:0] : !is64 || |low;
  endfunction
endpackage

// File: rtl/data_mem_lane.sv
// data_mem_lane: byte enables, store alignment and load extract/extend for one memory word
module data_mem_lane import data_mem_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [1:0]                      size,
  input  logic [$clog2(DATA_W/8)-1:0]     lane,
  input  logic                            isSigned,
  input  logic [DATA_W-1:0]               storeData,
  input  logic [DATA_W-1:0]               wordData,
  output logic [DATA_W/8-1:0]             byteEn,
  output logic [DATA_W-1:0]               storeWord,
  output logic [DATA_W-1:0]               loadData
);
  localparam int NB = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  logic [LANE_W+2:0] shAmt;
  logic [NB-1:0] sizeMask;
  logic [DATA_W-1:0] shifted, keep;
  logic signBit;
  // shift the addressed bytes to/from bit 0 and sign- or zero-fill above the access size
  always_comb begin
    shAmt = {lane, 3'b000};
    sizeMask = size == SZ_B ? NB'(1) : size == SZ_H ? NB'(3) : size == SZ_W ? NB'(15) : '1;
    byteEn = sizeMask << lane;
    storeWord = storeData << shAmt;
    shifted = wordData >> shAmt;
    keep = size == SZ_B ? DATA_W'(8'hFF) : size == SZ_H ? DATA_W'(16'hFFFF) : size == SZ_W ? DATA_W'(32'hFFFF_FFFF) : '1;
    signBit = size == SZ_B ? shifted[7] : size == SZ_H ? shifted[15] : size == SZ_W ? shifted[31] : shifted[DATA_W-1];
    loadData = (shifted & keep) | ({DATA_W{isSigned & signBit}} & ~keep);
  end
endmodule

// File: rtl/data_mem_hs.sv
// data_mem_hs: handshaked byte-addressed RAM with configurable latency and sized loads/stores
module data_mem_hs import data_mem_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 256,
  parameter int ADDR_W = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] ReadData
);
  localparam int NB = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  state_t state, nextState;
  logic [3:0] count;
  logic wrReg, signedReg;
  logic [1:0] sizeReg;
  logic [ADDR_W-1:0] addrReg;
  logic [DATA_W-1:0] dataReg;
  logic curWrite, curSigned, misaligned, commit, unusedAddr;
  logic [1:0] curSize;
  logic [ADDR_W-1:0] curAddr;
  logic [DATA_W-1:0] curData, storeWord, loadData;
  logic [NB-1:0] byteEn;
  logic [IDX_W-1:0] idx;
  logic [DATA_W-1:0] mem [DEPTH];
  // with zero wait states the access happens on the accepting edge, so IDLE uses live inputs
  always_comb begin
    curWrite = state == IDLE ? req_write : wrReg;
    curSigned = state == IDLE ? req_signed : signedReg;
    curSize = state == IDLE ? req_size : sizeReg;
    curAddr = state == IDLE ? Address : addrReg;
    curData = state == IDLE ? WriteData : dataReg;
    idx = curAddr[IDX_W+LANE_W-1:LANE_W];
    unusedAddr = ^curAddr[ADDR_W-1:IDX_W+LANE_W];
    misaligned = isMisaligned(curSize, 3'(curAddr[LANE_W-1:0]), DATA_W == 64);
    nextState = state == IDLE ? (req_valid ? (WAIT_STATES == 0 ? RESP : BUSY) : IDLE)
              : state == BUSY ? (count == 4'd1 ? RESP : BUSY) : IDLE;
    commit = nextState == RESP;
    req_ready = state == IDLE;
    resp_valid = state == RESP;
  end
  data_mem_lane #(.DATA_W(DATA_W)) lane (
    .size(curSize), .lane(curAddr[LANE_W-1:0]), .isSigned(curSigned), .storeData(curData),
    .wordData(mem[idx]), .byteEn(byteEn), .storeWord(storeWord), .loadData(loadData)
  );
  // FSM, wait counter, request capture while idle, and response registers loaded on entry to RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      wrReg <= 1'b0;
      signedReg <= 1'b0;
      sizeReg <= '0;
      addrReg <= '0;
      dataReg <= '0;
      resp_err <= 1'b0;
      ReadData <= '0;
    end else begin
      state <= nextState;
      count <= state == BUSY ? count - 4'd1 : 4'(WAIT_STATES);
      if (state == IDLE) begin
        wrReg <= req_write;
        signedReg <= req_signed;
        sizeReg <= req_size;
        addrReg <= Address;
        dataReg <= WriteData;
      end
      if (commit) begin
        resp_err <= misaligned;
        ReadData <= misaligned || curWrite ? '0 : loadData;
      end
    end
  end
  // byte-masked store commit; never while reset is held so dropped stores leave RAM untouched
  always_ff @(posedge clk) begin
    if (!rst && commit && curWrite && !misaligned)
      for (int i = 0; i < NB; i++)
        if (byteEn[i]) mem[idx][i*8 +: 8] <= storeWord[i*8 +: 8];
  end
endmodule

// File: tb/tb_data_mem_hs.sv
// tb_data_mem_hs: directed vector checks of data_mem_hs at zero and three wait states
module tb_data_mem_hs;
  logic clk = 1'b0;
  logic [1:0] rst = 2'b11;
  logic [1:0] reqValid = 2'b00;
  logic reqWrite = 1'b0, reqSigned = 1'b0;
  logic [1:0] reqSize = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic [1:0] reqReady, respValid, respErr;
  logic [1:0][31:0] rdData;
  int passCnt = 0, total = 0;

  always #5 clk = ~clk;

  data_mem_hs #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_write(reqWrite),
    .req_size(reqSize), .req_signed(reqSigned), .Address(addr), .WriteData(wdata),
    .resp_valid(respValid[0]), .resp_err(respErr[0]), .ReadData(rdData[0])
  );
  data_mem_hs #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst[1]), .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_write(reqWrite),
    .req_size(reqSize), .req_signed(reqSigned), .Address(addr), .WriteData(wdata),
    .resp_valid(respValid[1]), .resp_err(respErr[1]), .ReadData(rdData[1])
  );

  typedef struct {
    int d;
    logic w;
    logic [1:0] sz;
    logic sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] expRd;
    logic expErr;
    logic chkRd;
  } vec_t;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  function automatic vec_t mk(int d, logic w, logic [1:0] sz, logic sg, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] expRd, logic expErr, logic chkRd = 1'b1);
    vec_t v;
    v.d = d; v.w = w; v.sz = sz; v.sg = sg; v.a = a; v.wd = wd;
    v.expRd = expRd; v.expErr = expErr; v.chkRd = chkRd;
    return v;
  endfunction

  task automatic doReq(input vec_t v, input string nm);
    int n = 0;
    int lat = 1;
    logic busyOk = 1'b1;
    @(negedge clk);
    while (!reqReady[v.d] && n < 20) begin @(negedge clk); n++; end
    reqWrite = v.w; reqSize = v.sz; reqSigned = v.sg; addr = v.a; wdata = v.wd;
    reqValid[v.d] = 1'b1;
    @(posedge clk); #1;
    reqValid[v.d] = 1'b0;
    addr = v.a ^ 32'h0000_0F04; wdata = ~v.wd; reqWrite = ~v.w; reqSize = ~v.sz;
    while (!respValid[v.d] && lat < 40) begin
      if (reqReady[v.d]) busyOk = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, 32'(lat), v.d == 1 ? 32'd4 : 32'd1);
    chk({nm, "_busy_ready"}, 32'(busyOk), 32'd1);
    chk({nm, "_err"}, 32'(respErr[v.d]), 32'(v.expErr));
    if (v.chkRd) chk({nm, "_rd"}, rdData[v.d], v.expRd);
    @(posedge clk); #1;
    chk({nm, "_pulse"}, 32'(respValid[v.d]), 32'd0);
    chk({nm, "_ready_back"}, 32'(reqReady[v.d]), 32'd1);
    if (v.chkRd) chk({nm, "_rd_hold"}, rdData[v.d], v.expRd);
  endtask

  initial begin
    vec_t vecs[$];
    logic seen;
    vecs.push_back(mk(0, 0, 2'b10, 0, 20, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 2'b10, 0, 20, 32'h9999_9999, 0, 0));
    vecs.push_back(mk(0, 1, 2'b10, 0, 40, 32'hEEEE_EEEE, 0, 0));
    vecs.push_back(mk(0, 0, 2'b10, 0, 20, 0, 32'h9999_9999, 0));
    vecs.push_back(mk(0, 0, 2'b10, 0, 40, 0, 32'hEEEE_EEEE, 0));
    vecs.push_back(mk(0, 1, 2'b00, 0, 21, 32'h0000_0080, 0, 0));
    vecs.push_back(mk(0, 0, 2'b10, 1, 20, 0, 32'h9999_8099, 0));
    vecs.push_back(mk(0, 0, 2'b00, 1, 21, 0, 32'hFFFF_FF80, 0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 21, 0, 32'h0000_0080, 0));
    vecs.push_back(mk(0, 0, 2'b01, 0, 21, 0, 0, 1));
    vecs.push_back(mk(0, 0, 2'b10, 0, 22, 0, 0, 1));
    vecs.push_back(mk(0, 1, 2'b10, 0, 22, 32'h1234_5678, 0, 1));
    vecs.push_back(mk(0, 0, 2'b10, 0, 20, 0, 32'h9999_8099, 0));
    vecs.push_back(mk(0, 0, 2'b11, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 2'b01, 1, 22, 0, 32'hFFFF_9999, 0));
    vecs.push_back(mk(0, 0, 2'b01, 0, 20, 0, 32'h0000_8099, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 42, 32'h0000_1234, 0, 0));
    vecs.push_back(mk(0, 0, 2'b10, 0, 40, 0, 32'h1234_EEEE, 0));
    vecs.push_back(mk(0, 0, 2'b10, 0, 1064, 0, 32'h1234_EEEE, 0));
    vecs.push_back(mk(0, 1, 2'b10, 0, 1064, 32'hEEEE_EEEE, 0, 0));
    vecs.push_back(mk(0, 0, 2'b10, 0, 40, 0, 32'hEEEE_EEEE, 0));
    vecs.push_back(mk(1, 1, 2'b10, 0, 40, 32'hEEEE_EEEE, 0, 0));
    vecs.push_back(mk(1, 0, 2'b10, 0, 40, 0, 32'hEEEE_EEEE, 0));
    vecs.push_back(mk(1, 0, 2'b01, 1, 41, 0, 0, 1));

    repeat (2) @(negedge clk);
    rst = 2'b00;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset%0d_ready", d), 32'(reqReady[d]), 32'd1);
      chk($sformatf("reset%0d_valid", d), 32'(respValid[d]), 32'd0);
      chk($sformatf("reset%0d_err", d), 32'(respErr[d]), 32'd0);
      chk($sformatf("reset%0d_rd", d), rdData[d], 32'd0);
    end

    foreach (vecs[i]) doReq(vecs[i], $sformatf("v%0d", i));

    @(negedge clk);
    reqWrite = 1'b1; reqSize = 2'b10; reqSigned = 1'b0; addr = 40; wdata = 32'h1234_5678;
    reqValid[1] = 1'b1;
    @(posedge clk); #1;
    reqValid[1] = 1'b0;
    seen = respValid[1];
    @(negedge clk);
    rst[1] = 1'b1;
    reqValid[1] = 1'b1;
    @(negedge clk);
    seen |= respValid[1];
    reqValid[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b0;
    repeat (8) begin @(negedge clk); seen |= respValid[1]; end
    chk("rst_no_resp", 32'(seen), 32'd0);
    chk("rst_ready", 32'(reqReady[1]), 32'd1);
    chk("rst_rd_cleared", rdData[1], 32'd0);
    doReq(mk(1, 0, 2'b10, 0, 40, 0, 32'hEEEE_EEEE, 0), "rst_load40");
    doReq(mk(1, 0, 2'b10, 0, 1064, 0, 32'hEEEE_EEEE, 0), "rst_alias");

    $display("%0d/%0d checks passed", passCnt, total);
    $finish;
  end
endmodule
